// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer for a single multiply-accumulate processing element.
// A job clears the PE accumulator, streams RFW operand pairs into the PE
// register files, runs RFW multiply/rotate beats, optionally adds an external
// partial sum, then presents the PE result on a valid/ready handshake.
// The controller does no arithmetic; it only drives PE enables.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, use_psum, wht_keep  job request and per-job options (IDLE only)
//   in_valid/in_ready          operand stream handshake (in_if, in_wht)
//   psum_valid/psum_ready      external partial-sum handshake
//   out_valid/out_ready        result handshake (result read from PE out bus)
//   busy, done                 job in progress / one-cycle completion pulse
//   if_i_en .. psum_i_en       PE control strobes (mul_une/add_une active-low)
//   pe_in, pe_wht              PE operand buses
module pe_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int KERNEL_SIZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       use_psum,
  input  logic       wht_keep,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_if,
  input  logic [7:0] in_wht,
  input  logic       psum_valid,
  output logic       psum_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       if_i_en,
  output logic       wht_i_en,
  output logic       reg_sft_en,
  output logic       mul_une,
  output logic       add_une,
  output logic       acc_rst,
  output logic       psum_sel,
  output logic       psum_acc_start,
  output logic       psum_i_en,
  output logic [7:0] pe_in,
  output logic [7:0] pe_wht
);

  localparam int RFW = CHANNELS * KERNEL_SIZE;
  localparam int CW  = $clog2(RFW + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(RFW - 1);
  localparam logic [CW-1:0] MAC_LAST  = CW'(RFW);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    MAC,
    PSUM,
    OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          use_psum_q, use_psum_d;
  logic          wht_keep_q, wht_keep_d;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      use_psum_q <= 1'b0;
      wht_keep_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      use_psum_q <= use_psum_d;
      wht_keep_q <= wht_keep_d;
    end
  end

  assign accept = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    use_psum_d     = use_psum_q;
    wht_keep_d     = wht_keep_q;
    in_ready       = 1'b0;
    psum_ready     = 1'b0;
    out_valid      = 1'b0;
    done           = 1'b0;
    if_i_en        = 1'b0;
    wht_i_en       = 1'b0;
    reg_sft_en     = 1'b0;
    mul_une        = 1'b1;
    add_une        = 1'b1;
    acc_rst        = 1'b0;
    psum_sel       = 1'b0;
    psum_acc_start = 1'b0;
    psum_i_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          use_psum_d = use_psum;
          wht_keep_d = wht_keep;
        end
      end

      CLEAR: begin
        acc_rst = 1'b1;
        add_une = 1'b0;
        cnt_d   = '0;
        state_d = LOAD;
      end

      LOAD: begin
        in_ready = 1'b1;
        if_i_en  = accept;
        wht_i_en = accept & ~wht_keep_q;
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = MAC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      MAC: begin
        // The product register lags the register-file tap by one beat, so
        // the adder idles on beat 0 and drains the last product on beat RFW.
        if (cnt_q != MAC_LAST) begin
          mul_une    = 1'b0;
          reg_sft_en = 1'b1;
        end
        add_une = (cnt_q == '0);
        if (cnt_q == MAC_LAST) begin
          cnt_d   = '0;
          state_d = use_psum_q ? PSUM : OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PSUM: begin
        psum_ready = 1'b1;
        add_une    = ~psum_valid;
        if (psum_valid) begin
          psum_sel       = 1'b1;
          psum_i_en      = 1'b1;
          psum_acc_start = 1'b1;
          state_d        = OUT;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign pe_in  = in_if;
  assign pe_wht = in_wht;

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl: drives jobs through the controller, models the PE it
// steers, and compares the PE result and handshake behaviour to values
// derived from the operand/psum arithmetic.
module tb_pe_ctrl;

  localparam int RFW = 12;

  logic       clk, rst_n, start, use_psum, wht_keep;
  logic       in_valid, in_ready, psum_valid, psum_ready, out_valid, out_ready;
  logic       busy, done, if_i_en, wht_i_en, reg_sft_en, mul_une, add_une;
  logic       acc_rst, psum_sel, psum_acc_start, psum_i_en;
  logic [7:0] in_if, in_wht, pe_in, pe_wht;

  pe_ctrl #(.CHANNELS(4), .KERNEL_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_psum(use_psum),
    .wht_keep(wht_keep), .in_valid(in_valid), .in_ready(in_ready),
    .in_if(in_if), .in_wht(in_wht), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .if_i_en(if_i_en), .wht_i_en(wht_i_en),
    .reg_sft_en(reg_sft_en), .mul_une(mul_une), .add_une(add_une),
    .acc_rst(acc_rst), .psum_sel(psum_sel), .psum_acc_start(psum_acc_start),
    .psum_i_en(psum_i_en), .pe_in(pe_in), .pe_wht(pe_wht)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE model: shift-in register files with a tap at the far end, rotate on
  // reg_sft_en, registered product, accumulator with acc_rst priority.
  logic [7:0]  if_rf [RFW];
  logic [7:0]  wht_rf[RFW];
  logic [15:0] prod;
  logic [31:0] acc, psum_data;

  initial begin
    for (int i = 0; i < RFW; i++) begin
      if_rf[i]  = '0;
      wht_rf[i] = '0;
    end
    prod = '0;
    acc  = '0;
  end

  always @(posedge clk) begin
    if (if_i_en) begin
      for (int i = RFW - 1; i > 0; i--) if_rf[i] <= if_rf[i-1];
      if_rf[0] <= pe_in;
    end else if (reg_sft_en) begin
      for (int i = RFW - 1; i > 0; i--) if_rf[i] <= if_rf[i-1];
      if_rf[0] <= if_rf[RFW-1];
    end
    if (wht_i_en) begin
      for (int i = RFW - 1; i > 0; i--) wht_rf[i] <= wht_rf[i-1];
      wht_rf[0] <= pe_wht;
    end else if (reg_sft_en) begin
      for (int i = RFW - 1; i > 0; i--) wht_rf[i] <= wht_rf[i-1];
      wht_rf[0] <= wht_rf[RFW-1];
    end
    if (!mul_une) prod <= if_rf[RFW-1] * wht_rf[RFW-1];
    if (acc_rst) acc <= '0;
    else if (!add_une) acc <= acc + (psum_sel ? psum_data : {{16{prod[15]}}, prod});
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  localparam logic [13:0] IDLE_V = 14'b00000000110000;
  function automatic logic [13:0] outs();
    return {in_ready, psum_ready, out_valid, busy, done, if_i_en, wht_i_en,
            reg_sft_en, mul_une, add_une, acc_rst, psum_sel, psum_acc_start, psum_i_en};
  endfunction

  logic [7:0] cur_if[RFW], cur_wht[RFW], res_w[RFW];
  bit         wht_ok;
  int r_lat, r_load, r_nif, r_nwht, r_done, r_psr, r_psacc, r_stall_bad;
  bit r_timeout, r_idle_after;
  logic [31:0] r_res;

  // Run one job to completion; cycle 0 is the cycle in which start is high.
  task automatic run_job(input bit up, input bit keep, input int mode,
                         input logic [31:0] ps, input int ps_dly,
                         input int out_dly, input bit pulse_start);
    int cyc, beat, ps_seen, ov_seen;
    logic [31:0] acc_hold;
    bit fin;
    cyc = 0; beat = 0; ps_seen = 0; ov_seen = 0; fin = 0; acc_hold = '0;
    r_lat = -1; r_load = 0; r_nif = 0; r_nwht = 0; r_done = 0;
    r_psr = 0; r_psacc = 0; r_stall_bad = 0; r_timeout = 0; r_res = '0;
    use_psum = up; wht_keep = keep; psum_data = ps; start = 1'b1;
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start      = 1'b0;
      in_valid   = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
      in_if      = (beat < RFW) ? cur_if[beat]  : 8'h00;
      in_wht     = (beat < RFW) ? cur_wht[beat] : 8'h00;
      psum_valid = up && (ps_seen >= ps_dly);
      out_ready  = (ov_seen >= out_dly);
      #1;
      if (in_ready) begin
        r_load++;
        if (in_valid) beat++;
      end
      r_nif  += int'(if_i_en);
      r_nwht += int'(wht_i_en);
      r_done += int'(done);
      if (psum_ready) begin
        r_psr++;
        if (psum_valid) r_psacc++;
        else ps_seen++;
      end
      if (out_valid) begin
        if (r_lat < 0) begin
          r_lat = cyc;
          acc_hold = acc;
        end else if (acc !== acc_hold) r_stall_bad++;
        if (out_ready) begin
          fin = 1;
          r_res = acc;
        end else begin
          ov_seen++;
          start = pulse_start;
        end
      end else if (r_lat >= 0) r_stall_bad++;
    end
    r_timeout = !fin;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    #1;
    r_idle_after = !busy && !done;
  endtask

  typedef struct {
    bit          up;
    bit          keep;
    int          mode;
    logic [31:0] ps;
    int          ps_dly;
    int          out_dly;
    bit          pulse;
    bit          ones;
    logic [7:0]  w;
    logic [31:0] exp_res;
    int          exp_lat;
    int          exp_load;
    int          exp_nwht;
    int          exp_psr;
  } vec_t;

  vec_t tbl[5];
  logic [31:0] exp_r;
  logic [15:0] p;

  initial begin
    //            up keep mode ps   dly od pulse ones w  res   lat load nwht psr
    tbl[0] = '{1'b0, 1'b0, 0, 32'd0,    0, 0, 1'b0, 1'b0, 8'd2, 32'd156,  27, 12, 12, 0};
    tbl[1] = '{1'b1, 1'b0, 0, 32'd1000, 3, 0, 1'b0, 1'b0, 8'd2, 32'd1156, 31, 12, 12, 4};
    tbl[2] = '{1'b0, 1'b0, 1, 32'd0,    0, 0, 1'b0, 1'b0, 8'd2, 32'd156,  39, 24, 12, 0};
    tbl[3] = '{1'b0, 1'b1, 0, 32'd0,    0, 0, 1'b0, 1'b1, 8'd9, 32'd24,   27, 12, 0,  0};
    tbl[4] = '{1'b0, 1'b0, 0, 32'd0,    0, 5, 1'b1, 1'b0, 8'd2, 32'd156,  27, 12, 12, 0};

    rst_n = 1'b0; start = 1'b1; use_psum = 1'b1; wht_keep = 1'b1;
    in_valid = 1'b1; in_if = 8'hA5; in_wht = 8'h3C; psum_valid = 1'b1;
    out_ready = 1'b1; psum_data = '0; wht_ok = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), IDLE_V);
    chk("pe_in_pass", pe_in, 8'hA5);
    chk("pe_wht_pass", pe_wht, 8'h3C);
    start = 1'b0; in_valid = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", outs(), IDLE_V);

    foreach (tbl[k]) begin
      for (int i = 0; i < RFW; i++) begin
        cur_if[i]  = tbl[k].ones ? 8'd1 : 8'(i + 1);
        cur_wht[i] = tbl[k].w;
      end
      run_job(tbl[k].up, tbl[k].keep, tbl[k].mode, tbl[k].ps, tbl[k].ps_dly,
              tbl[k].out_dly, tbl[k].pulse);
      if (!tbl[k].keep) begin
        res_w = cur_wht;
        wht_ok = 1;
      end
      chk($sformatf("v%0d_timeout", k), r_timeout, 0);
      chk($sformatf("v%0d_result", k), r_res, tbl[k].exp_res);
      chk($sformatf("v%0d_out_cycle", k), r_lat, tbl[k].exp_lat);
      chk($sformatf("v%0d_load_cycles", k), r_load, tbl[k].exp_load);
      chk($sformatf("v%0d_if_pulses", k), r_nif, RFW);
      chk($sformatf("v%0d_wht_pulses", k), r_nwht, tbl[k].exp_nwht);
      chk($sformatf("v%0d_psum_ready_cycles", k), r_psr, tbl[k].exp_psr);
      chk($sformatf("v%0d_psum_accepts", k), r_psacc, tbl[k].up ? 1 : 0);
      chk($sformatf("v%0d_done_pulses", k), r_done, 1);
      chk($sformatf("v%0d_out_stable", k), r_stall_bad, 0);
      chk($sformatf("v%0d_idle_after", k), r_idle_after, 1);
    end

    // Reset asserted in the middle of MAC (count 5, cycle 19).
    for (int i = 0; i < RFW; i++) begin
      cur_if[i]  = 8'(i + 1);
      cur_wht[i] = 8'd2;
    end
    use_psum = 1'b0; wht_keep = 1'b0; start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_if    = (c >= 2 && c <= 13) ? cur_if[c-2]  : 8'h00;
      in_wht   = (c >= 2 && c <= 13) ? cur_wht[c-2] : 8'h00;
    end
    #1;
    chk("mac_before_reset", {reg_sft_en, mul_une, busy}, 3'b101);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mac_immediate", outs(), IDLE_V);
    @(posedge clk); #1;
    chk("reset_mid_mac_held", outs(), IDLE_V);
    rst_n = 1'b1; in_valid = 1'b0;
    wht_ok = 0;
    @(posedge clk); #1;
    run_job(1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b0);
    res_w = cur_wht; wht_ok = 1;
    chk("post_reset_result", r_res, 32'd156);
    chk("post_reset_out_cycle", r_lat, 27);
    chk("post_reset_done", r_done, 1);

    // Randomised jobs against the arithmetic reference.
    for (int j = 0; j < 20; j++) begin
      bit up, keep;
      logic [31:0] ps;
      up   = $urandom_range(0, 1) == 1;
      keep = wht_ok && ($urandom_range(0, 2) == 0);
      ps   = $urandom;
      for (int i = 0; i < RFW; i++) begin
        cur_if[i]  = 8'($urandom);
        cur_wht[i] = 8'($urandom);
      end
      if (!keep) res_w = cur_wht;
      exp_r = up ? ps : 32'd0;
      for (int i = 0; i < RFW; i++) begin
        p = 16'(cur_if[i] * res_w[i]);
        exp_r = exp_r + {{16{p[15]}}, p};
      end
      run_job(up, keep, 2, ps, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      chk($sformatf("rnd%0d_timeout", j), r_timeout, 0);
      chk($sformatf("rnd%0d_result", j), r_res, exp_r);
      chk($sformatf("rnd%0d_if_pulses", j), r_nif, RFW);
      chk($sformatf("rnd%0d_wht_pulses", j), r_nwht, keep ? 0 : RFW);
      chk($sformatf("rnd%0d_psum_accepts", j), r_psacc, up ? 1 : 0);
      chk($sformatf("rnd%0d_done_pulses", j), r_done, 1);
      chk($sformatf("rnd%0d_out_stable", j), r_stall_bad, 0);
      chk($sformatf("rnd%0d_idle_after", j), r_idle_after, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
